// File: rtl/gate_deadtime_driver.sv
// gate_deadtime_driver: complementary half-bridge gate drive with dead time,
// minimum on-time, enable gating and a switching-event counter.
//
// Ports:
//   i_clk, i_reset (async, active low)
//   i_enable   : 0 forces both gates off
//   i_sigma    : 1 = high side requested, 0 = low side requested
//   dead_time  : dead-time length in cycles (0 behaves as 1)
//   min_on     : minimum on-time of either gate in cycles
//   o_gate_H/L : gate commands, never both high
//   o_busy     : in a dead-time state
//   o_pending  : commutation requested but min_on not yet reached
//   o_sw_count : ON-state entries, wrapping
module gate_deadtime_driver #(
   parameter int CNT_W = 16,
   parameter int EVT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_enable,
   input  logic             i_sigma,
   input  logic [CNT_W-1:0] dead_time,
   input  logic [CNT_W-1:0] min_on,
   output logic             o_gate_H,
   output logic             o_gate_L,
   output logic             o_busy,
   output logic             o_pending,
   output logic [EVT_W-1:0] o_sw_count
);

   typedef enum logic [2:0] {
      S_OFF,
      S_DT_H,
      S_DT_L,
      S_ON_H,
      S_ON_L
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] cnt_sat, dt_eff;
   logic [EVT_W-1:0] sw_cnt;
   logic             sw_inc;

   assign dt_eff  = (dead_time == '0) ? CNT_W'(1) : dead_time;
   assign cnt_sat = (cnt == '1) ? cnt : cnt + CNT_W'(1);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      sw_inc    = 1'b0;
      if (!i_enable) begin
         state_nxt = S_OFF;
         cnt_nxt   = '0;
      end else begin
         unique case (state)
            S_OFF: begin
               state_nxt = i_sigma ? S_DT_H : S_DT_L;
               cnt_nxt   = CNT_W'(1);
            end
            S_DT_H, S_DT_L: begin
               // sigma is ignored here: the commutation always completes
               if (cnt >= dt_eff) begin
                  state_nxt = (state == S_DT_H) ? S_ON_H : S_ON_L;
                  cnt_nxt   = CNT_W'(1);
                  sw_inc    = 1'b1;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            S_ON_H: begin
               if (!i_sigma && cnt >= min_on) begin
                  state_nxt = S_DT_L;
                  cnt_nxt   = CNT_W'(1);
               end else begin
                  cnt_nxt = cnt_sat;
               end
            end
            S_ON_L: begin
               if (i_sigma && cnt >= min_on) begin
                  state_nxt = S_DT_H;
                  cnt_nxt   = CNT_W'(1);
               end else begin
                  cnt_nxt = cnt_sat;
               end
            end
            default: begin
               state_nxt = S_OFF;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state  <= S_OFF;
         cnt    <= '0;
         sw_cnt <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (sw_inc) sw_cnt <= sw_cnt + EVT_W'(1);
      end
   end

   assign o_gate_H   = (state == S_ON_H);
   assign o_gate_L   = (state == S_ON_L);
   assign o_busy     = (state == S_DT_H) || (state == S_DT_L);
   assign o_sw_count = sw_cnt;

   // Request for the other side is visible before min_on has elapsed
   assign o_pending  = (cnt < min_on) &&
                       (((state == S_ON_H) && !i_sigma) ||
                        ((state == S_ON_L) &&  i_sigma));

endmodule

// File: tb/tb_gate_deadtime_driver.sv
// tb_gate_deadtime_driver: scoreboard bench for gate_deadtime_driver.
// Expected per-cycle outputs are queued by the driver, popped at negedge.
module tb_gate_deadtime_driver;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_enable;
   logic        i_sigma;
   logic [15:0] dead_time;
   logic [15:0] min_on;
   logic        o_gate_H;
   logic        o_gate_L;
   logic        o_busy;
   logic        o_pending;
   logic [15:0] o_sw_count;

   int          errs   = 0;
   int          checks = 0;
   string       tq[$];
   logic [19:0] vq[$];
   logic [15:0] swc;

   gate_deadtime_driver #(.CNT_W(16), .EVT_W(16)) dut (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_enable   (i_enable),
      .i_sigma    (i_sigma),
      .dead_time  (dead_time),
      .min_on     (min_on),
      .o_gate_H   (o_gate_H),
      .o_gate_L   (o_gate_L),
      .o_busy     (o_busy),
      .o_pending  (o_pending),
      .o_sw_count (o_sw_count)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // queue one cycle of expected {H,L,busy,pending,count}
   task automatic cyc(input string tag, input logic h, input logic l,
                      input logic b, input logic p, input logic [15:0] c);
      tq.push_back(tag);
      vq.push_back({h, l, b, p, c});
      @(negedge i_clk);
      #1;
   endtask

   task automatic busy(input string tag, input int n);
      for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b0, 1'b1, 1'b0, swc);
   endtask

   task automatic on_h(input string tag, input int n, input logic p);
      for (int i = 0; i < n; i++) cyc(tag, 1'b1, 1'b0, 1'b0, p, swc);
   endtask

   task automatic on_l(input string tag, input int n, input logic p);
      for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b1, 1'b0, p, swc);
   endtask

   task automatic off(input string tag, input int n);
      for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b0, 1'b0, 1'b0, swc);
   endtask

   always @(negedge i_clk) begin
      string       t;
      logic [19:0] e;
      check("excl", {31'b0, o_gate_H & o_gate_L}, 32'd0);
      if (vq.size() > 0) begin
         t = tq.pop_front();
         e = vq.pop_front();
         check(t, {12'b0, o_gate_H, o_gate_L, o_busy, o_pending, o_sw_count},
               {12'b0, e});
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      i_reset   = 1'b0;
      i_enable  = 1'b1;
      i_sigma   = 1'b1;
      dead_time = 16'd5;
      min_on    = 16'd10;
      swc       = 16'd0;

      // reset hold, then release into full dead time
      off("rst_hold", 3);
      i_reset = 1'b1;
      busy("dt5_h", 5);
      swc++;
      on_h("on_h", 1, 1'b0);
      dead_time = 16'd3;
      on_h("on_h", 19, 1'b0);

      // commutation H -> L
      i_sigma = 1'b0;
      busy("dt3_l", 3);
      swc++;
      on_l("on_l", 4, 1'b0);

      // min on-time: request at count 4, switch at count 10
      i_sigma = 1'b1;
      #1;
      check("pend_now", {31'b0, o_pending}, 32'd1);
      on_l("pend", 5, 1'b1);
      on_l("min_on", 1, 1'b0);
      busy("dt3_h", 3);
      swc++;
      on_h("on_h2", 1, 1'b0);

      // glitch during DT_TO_H, short min_on
      dead_time = 16'd8;
      min_on    = 16'd2;
      i_sigma   = 1'b0;
      on_h("short_h", 1, 1'b0);
      busy("dt8_l", 8);
      swc++;
      on_l("on_l3", 1, 1'b0);
      i_sigma = 1'b1;
      on_l("short_l", 1, 1'b0);
      busy("dt8_h", 3);
      i_sigma = 1'b0;
      busy("glitch", 5);
      swc++;
      on_h("glitch_on", 1, 1'b1);
      on_h("glitch_on2", 1, 1'b0);
      busy("dt8_l2", 8);
      swc++;
      on_l("on_l4", 1, 1'b0);

      // enable drop mid-ON and mid-DT
      dead_time = 16'd3;
      min_on    = 16'd0;
      i_enable  = 1'b0;
      off("off_on", 2);
      i_enable = 1'b1;
      i_sigma  = 1'b1;
      busy("reen_h", 3);
      swc++;
      on_h("reen_on_h", 1, 1'b0);
      i_sigma = 1'b0;
      busy("dt_mid", 2);
      i_enable = 1'b0;
      off("off_dt", 1);
      i_enable = 1'b1;
      busy("reen_l", 3);
      swc++;
      on_l("reen_on_l", 1, 1'b0);

      // dead_time = 0 gives a single DT cycle
      dead_time = 16'd0;
      i_sigma   = 1'b1;
      busy("dt0", 1);
      swc++;
      on_h("dt0_on", 1, 1'b0);

      // event counter wrap
      force dut.sw_cnt = 16'hFFFF;
      #1;
      release dut.sw_cnt;
      swc     = 16'hFFFF;
      i_sigma = 1'b0;
      busy("pre_wrap", 1);
      swc++;
      on_l("wrap", 1, 1'b0);

      // async reset mid-commutation
      dead_time = 16'd4;
      i_sigma   = 1'b1;
      busy("dt4", 2);
      i_reset = 1'b0;
      #1;
      check("async_rst",
            {13'b0, o_gate_H, o_gate_L, o_busy, o_sw_count}, 32'd0);
      swc = 16'd0;
      off("rst_mid", 1);
      i_reset = 1'b1;
      busy("post_rst", 4);
      swc++;
      on_h("post_on", 1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/gate_deadtime_driver.md
Name: gate_deadtime_driver

Overview:
- Transmit-side counterpart of the switching-signal conditioning chain: it takes the regularized switching command sigma and drives the half-bridge as a complementary high-side/low-side gate pair.
- Inserts a programmable dead time, during which both gates are off, at every commutation.
- Enforces a minimum on-time per gate.
- Provides an enable and a switching-event counter for monitoring.
- Sits between the hybrid-control logic and the FPGA gate-drive pins.

Parameters:
CNT_W, 16, width of the dead-time/on-time counter and of the dead_time/min_on inputs
EVT_W, 16, width of the switching-event counter

Ports:
i_clk  input  1  system clock
i_reset  input  1  asynchronous, active-low reset
i_enable  input  1  1 = bridge may switch; 0 = both gates forced off
i_sigma  input  1  switching command, already synchronous to i_clk (1 = high side on, 0 = low side on)
dead_time  input  CNT_W  dead-time length in clock cycles (0 treated as 1)
min_on  input  CNT_W  minimum on-time of either gate in clock cycles
o_gate_H  output  1  high-side gate command
o_gate_L  output  1  low-side gate command
o_busy  output  1  1 while in a dead-time state
o_pending  output  1  1 while sigma requests the other side but min_on has not yet elapsed
o_sw_count  output  EVT_W  number of ON-state entries, wraps

Behaviour:
- State register: OFF, DT_TO_H, DT_TO_L, ON_H, ON_L.
- Gates decode from the registered state: o_gate_H=1 only in ON_H; o_gate_L=1 only in ON_L.
- o_gate_H and o_gate_L are never 1 simultaneously in any cycle.
- Reset (i_reset=0, async): state=OFF, counter=0, o_sw_count=0, all outputs 0. These values are held while reset is low.
- OFF: both gates 0.
  - If i_enable=1: go to DT_TO_H if i_sigma=1, else DT_TO_L.
  - Counter loads 1.
- DT_TO_x: both gates 0, o_busy=1.
  - If counter >= max(dead_time,1): go to ON_x, load counter=1, increment o_sw_count.
  - Otherwise counter+1.
  - The DT state therefore lasts max(dead_time,1) cycles.
  - i_sigma changes during DT are ignored. The transition completes to ON_x and the new request is served from ON_x.
- ON_H (ON_L is symmetric):
  - Counter increments, saturating at 2^CNT_W-1.
  - If i_sigma=0 and counter >= min_on: go to DT_TO_L and load counter=1.
  - If i_sigma=0 and counter < min_on: stay in ON_H, o_pending=1.
  - min_on=0 allows switching on the first ON cycle.
- Commutation latency: i_sigma change sampled at edge k (min_on satisfied) → the active gate drops at edge k. The opposite gate rises max(dead_time,1) cycles later.
- i_enable=0 in any state: next state is OFF and gates go 0 at the next edge. This has priority over all other transitions.
- Re-enable always passes through a full DT state.
- dead_time/min_on are used live. A change mid-interval takes effect on the next comparison.
  - Lowering a value below the current count ends the interval at the next edge.
- o_pending is combinational from state, counter, i_sigma and min_on. It is 0 outside ON states.
- o_sw_count wraps 2^EVT_W-1 → 0.
- Reset asserted mid-commutation returns to OFF immediately (asynchronously), both gates 0.

Test Plan:
- Reset/enable: hold i_reset=0 with i_enable=1 and i_sigma=1 → gates 0, o_sw_count=0. Release reset with dead_time=5 → o_busy for 5 cycles, then o_gate_H=1, o_sw_count=1.
- Commutation: dead_time=3, min_on=10, in ON_H for 20 cycles; drop i_sigma → o_gate_H=0 next edge, 3 cycles both 0, then o_gate_L=1. Assert gates never both 1 throughout.
- Min on-time: min_on=10, toggle i_sigma 4 cycles after entering ON_L → o_pending=1 for 6 cycles. The switch occurs when counter reaches 10; no early commutation.
- Glitch during DT: dead_time=8, return i_sigma to its old value at cycle 3 of DT_TO_H → ON_H still entered. With min_on=2, ON_H lasts 2 cycles, then DT_TO_L.
- Enable drop: deassert i_enable mid-DT and mid-ON → OFF next edge, both gates 0. Re-enable → full dead time before any gate rises.
- Edge values: dead_time=0 → exactly 1 DT cycle. Preload o_sw_count to 0xFFFF via 65535 commutations (or force) → the next ON entry wraps it to 0.
